// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the serial adder host: the controller state encoding
// and the frame-length rule that links the operand width to the number of
// bit-serial cycles.
//
// Optional feature macro: SERIAL_ADDER_CARRY_EN
//   defined   -> frames are WIDTH+1 bits long and the carry-out is reported
//   undefined -> frames are WIDTH bits long and the carry-out reads as 0
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // Controller states, encoded to match the documented 3-bit values.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

`ifdef SERIAL_ADDER_CARRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    localparam int DEFAULT_WIDTH = 8;

    // One extra frame bit carries the zero-extension sum, which is the carry-out.
    function automatic int frameLen(input int width);
        return CARRY_EN ? width + 1 : width;
    endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// -----------------------------------------------------------------------------
// serial_word_shifter
// N-bit shift register with parallel load and right shift. New bits enter at
// the MSB and the LSB is presented as the serial output.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, clears the register
//   load_i       load loadData_i (takes priority over shift_i)
//   loadData_i   parallel load value
//   shift_i      shift right by one, serialIn_i entering at bit N-1
//   serialIn_i   bit shifted in at the MSB
//   parallel_o   current register contents
//   serialOut_o  current LSB
// -----------------------------------------------------------------------------
module serial_word_shifter
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [N-1:0] loadData_i,
    input  logic         shift_i,
    input  logic         serialIn_i,
    output logic [N-1:0] parallel_o,
    output logic         serialOut_o
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    // Next-state selection: a load wins over a shift, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = loadData_i;
        end else if (shift_i) begin
            data_d = {serialIn_i, data_q[N-1:1]};
        end
    end

    // Register update with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign parallel_o  = data_q;
    assign serialOut_o = data_q[0];

endmodule

// File: rtl/serial_adder_host.sv
// -----------------------------------------------------------------------------
// serial_adder_host
// Word-level front end for a Moore bit-serial adder. Accepts an operand pair,
// clears the adder for one cycle, shifts the operands out LSB-first, collects
// the adder's one-cycle-delayed sum stream and presents the parallel result.
//
// Optional feature macro: SERIAL_ADDER_CARRY_EN (adds one frame bit so the
// carry-out is collected and reported on out_carry; otherwise out_carry = 0).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   operand pair valid          in_ready   accepting (IDLE only)
//   in_a/in_b  WIDTH-bit operands
//   ser_a/b    serial operand bits to the adder
//   ser_clr    one-cycle synchronous clear to the adder
//   ser_sum    adder sum bit (one cycle behind ser_a/ser_b)
//   out_valid  result valid (DONE only)   out_ready  result accepted
//   out_sum    (in_a + in_b) mod 2^WIDTH  out_carry  carry-out
// -----------------------------------------------------------------------------
module serial_adder_host
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_clr,
    input  logic             ser_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int N     = frameLen(WIDTH);
    localparam int CNT_W = $clog2(N);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic         accept;
    logic         lastShift;
    logic         shifting;
    logic         capture;
    logic         opABit;
    logic         opBBit;
    logic [N-1:0] result;
    logic [N-1:0] opAWord;
    logic [N-1:0] opBWord;
    logic         resultTap;
    logic         unusedTaps;

    assign accept    = (state_q == IDLE) && in_valid;
    assign shifting  = (state_q == SHIFT);
    assign lastShift = (count_q == CNT_W'(N - 1));

    // The adder answers one cycle late, so the first SHIFT cycle has nothing
    // to collect yet and DRAIN picks up the bit from the last SHIFT cycle.
    assign capture = (shifting && (count_q != '0)) || (state_q == DRAIN);

    // State and bit-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: the counter tracks which SHIFT cycle is on the wire.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CLR;
                    count_d = '0;
                end
            end
            CLR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                count_d = count_q + CNT_W'(1);
                if (lastShift) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded purely from registered state so nothing on the
    // serial side depends combinationally on the word-side inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ser_clr   = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        unique case (state_q)
            IDLE:  in_ready  = 1'b1;
            CLR:   ser_clr   = 1'b1;
            SHIFT: begin
                ser_a = opABit;
                ser_b = opBBit;
            end
            DONE:  out_valid = 1'b1;
            default: begin
            end
        endcase
    end

    // Operand registers: zero-extended to the frame length on accept so the
    // extra frame bit (when present) adds the two zero MSBs plus the carry.
    serial_word_shifter #(.N(N)) opAShifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (accept),
        .loadData_i  (N'(in_a)),
        .shift_i     (shifting),
        .serialIn_i  (1'b0),
        .parallel_o  (opAWord),
        .serialOut_o (opABit)
    );

    serial_word_shifter #(.N(N)) opBShifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (accept),
        .loadData_i  (N'(in_b)),
        .shift_i     (shifting),
        .serialIn_i  (1'b0),
        .parallel_o  (opBWord),
        .serialOut_o (opBBit)
    );

    // Result register: cleared on accept, then N captured bits walk down from
    // the MSB so sum bit i ends up at position i.
    serial_word_shifter #(.N(N)) resultShifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (accept),
        .loadData_i  ('0),
        .shift_i     (capture),
        .serialIn_i  (ser_sum),
        .parallel_o  (result),
        .serialOut_o (resultTap)
    );

    // Parallel views of the operand registers and the result's serial tap
    // have no consumer in this block.
    assign unusedTaps = ^{opAWord, opBWord, resultTap};

    assign out_sum = result[WIDTH-1:0];

`ifdef SERIAL_ADDER_CARRY_EN
    assign out_carry = result[N-1];
`else
    assign out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_host.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_host
// Pairs serial_adder_host (WIDTH=8) with a Moore serial adder stand-in and
// checks results, frame timing, handshake behaviour and mid-frame reset.
// Works with SERIAL_ADDER_CARRY_EN either defined or undefined.
// -----------------------------------------------------------------------------
module tb_serial_adder_host;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + int'(serial_adder_pkg::CARRY_EN) + 3;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expSum;
        logic       carryIfEnabled;
    } vector_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       ser_a;
    logic       ser_b;
    logic       ser_clr;
    logic       ser_sum;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_carry;

    int assertCount = 0;
    int failCount   = 0;
    int clrCount    = 0;

    logic addSum;
    logic addCarry;

    vector_t    vectors[6];
    int         cyc;
    int         firstValid;
    int         secondAccept;
    int         secondValid;
    logic [7:0] a1, b1, a2, b2, ra, rb;

    always #5 clk = ~clk;

    serial_adder_host #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_clr   (ser_clr),
        .ser_sum   (ser_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    // Moore serial adder: registered sum and carry, cleared by system reset
    // or by the host's ser_clr pulse.
    always @(posedge clk) begin
        if (reset || ser_clr) begin
            addSum   <= 1'b0;
            addCarry <= 1'b0;
        end else begin
            addSum   <= ser_a ^ ser_b ^ addCarry;
            addCarry <= (ser_a & ser_b) | (ser_a & addCarry) | (ser_b & addCarry);
        end
    end
    assign ser_sum = addSum;

    // Count adder clear pulses seen at the active edge.
    always @(posedge clk) begin
        if (ser_clr) clrCount <= clrCount + 1;
    end

    // Reference model: plain word arithmetic.
    function automatic logic [7:0] modelSum(input logic [7:0] a, input logic [7:0] b);
        int unsigned total;
        total = int'(a) + int'(b);
        return 8'(total % 256);
    endfunction

    function automatic logic modelCarry(input logic [7:0] a, input logic [7:0] b);
        return serial_adder_pkg::CARRY_EN && ((int'(a) + int'(b)) > 255);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one frame starting at a negedge in IDLE; holdCycles keeps
    // out_ready low in DONE while stray in_valid pulses are driven.
    task automatic applyStimulus(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input int holdCycles, input logic [7:0] expSum,
                                 input logic expCarry);
        int n;
        int clrStart;
        checkOutput({name, " in_ready before"}, 32'(in_ready), 32'd1);
        clrStart  = clrCount;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (holdCycles == 0);
        n = 0;
        @(negedge clk);
        n = 1;
        in_valid = 1'b0;
        while (!out_valid && n < LAT + 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " latency"}, 32'(n), 32'(LAT));
        if (out_valid) begin
            for (int h = 0; h < holdCycles; h++) begin
                checkOutput({name, " hold out_valid"}, 32'(out_valid), 32'd1);
                checkOutput({name, " hold out_sum"}, 32'(out_sum), 32'(expSum));
                checkOutput({name, " hold in_ready"}, 32'(in_ready), 32'd0);
                in_a     = ~a;
                in_b     = b ^ 8'h5A;
                in_valid = 1'b1;
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            checkOutput({name, " out_sum"}, 32'(out_sum), 32'(expSum));
            checkOutput({name, " out_carry"}, 32'(out_carry), 32'(expCarry));
            @(negedge clk);
        end
        checkOutput({name, " ser_clr pulses"}, 32'(clrCount - clrStart), 32'd1);
        checkOutput({name, " in_ready after"}, 32'(in_ready), 32'd1);
        checkOutput({name, " out_valid after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vectors[0] = '{"add 05+03", 8'h05, 8'h03, 8'h08, 1'b0};
        vectors[1] = '{"add FF+01", 8'hFF, 8'h01, 8'h00, 1'b1};
        vectors[2] = '{"add FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vectors[3] = '{"add 00+00", 8'h00, 8'h00, 8'h00, 1'b0};
        vectors[4] = '{"add 80+80", 8'h80, 8'h80, 8'h00, 1'b1};
        vectors[5] = '{"add AA+55", 8'hAA, 8'h55, 8'hFF, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_sum", 32'(out_sum), 32'd0);
        checkOutput("reset out_carry", 32'(out_carry), 32'd0);
        checkOutput("reset ser_a", 32'(ser_a), 32'd0);
        checkOutput("reset ser_b", 32'(ser_b), 32'd0);
        checkOutput("reset ser_clr", 32'(ser_clr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vectors[i].name, vectors[i].a, vectors[i].b, 0, vectors[i].expSum,
                          vectors[i].carryIfEnabled & serial_adder_pkg::CARRY_EN);
        end

        $display("[TB] out_ready held low in DONE");
        applyStimulus("hold 12+34", 8'h12, 8'h34, 5, 8'h46, 1'b0);

        $display("[TB] reset in the 4th SHIFT cycle");
        in_a      = 8'h77;
        in_b      = 8'h11;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset out_sum", 32'(out_sum), 32'd0);
        checkOutput("midreset ser_a", 32'(ser_a), 32'd0);
        checkOutput("midreset ser_clr", 32'(ser_clr), 32'd0);
        reset = 1'b0;
        applyStimulus("post-reset 5A+33", 8'h5A, 8'h33, 0, 8'h8D, 1'b0);

        $display("[TB] back-to-back frames");
        a1 = 8'($urandom);
        b1 = 8'($urandom);
        a2 = 8'($urandom);
        b2 = 8'($urandom);
        firstValid   = -1;
        secondAccept = -1;
        secondValid  = -1;
        in_a      = a1;
        in_b      = b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (secondValid < 0 && cyc < 4 * LAT) begin
            @(negedge clk);
            cyc++;
            if (secondAccept >= 0 && cyc == secondAccept + 1) in_valid = 1'b0;
            if (out_valid) begin
                if (firstValid < 0) begin
                    firstValid = cyc;
                    checkOutput("b2b first sum", 32'(out_sum), 32'(modelSum(a1, b1)));
                    checkOutput("b2b first carry", 32'(out_carry), 32'(modelCarry(a1, b1)));
                end else begin
                    secondValid = cyc;
                    checkOutput("b2b second sum", 32'(out_sum), 32'(modelSum(a2, b2)));
                    checkOutput("b2b second carry", 32'(out_carry), 32'(modelCarry(a2, b2)));
                end
            end
            if (in_ready && secondAccept < 0) begin
                secondAccept = cyc;
                in_a = a2;
                in_b = b2;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b first valid cycle", 32'(firstValid), 32'(LAT));
        checkOutput("b2b second accept cycle", 32'(secondAccept), 32'(LAT + 1));
        checkOutput("b2b frame period", 32'(secondValid - firstValid), 32'(LAT + 1));

        $display("[TB] randomized frames");
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus("random", ra, rb, int'($urandom_range(0, 2)), modelSum(ra, rb),
                          modelCarry(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time limit so a stuck handshake can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
